// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer: collects four stream bytes into one 32-bit word and
// pulses word_valid for one cycle with the packed word.
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  count,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] shreg;
  logic [31:0] packed_next;

  // Shift the incoming byte in from the side that leaves the first byte in
  // the configured lane once four bytes have been collected.
  always_comb begin
    packed_next = '0;
    if (BIG_ENDIAN) packed_next = {shreg[23:0], byte_in};
    else            packed_next = {byte_in, shreg[31:8]};
  end

  // Byte counter, shift register and one-cycle word strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      count      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shreg <= '0;
        count <= '0;
      end else if (byte_en) begin
        shreg <= packed_next;
        count <= count + 2'd1;
        if (count == 2'(BYTES_PER_WORD - 1)) begin
          word       <= packed_next;
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte image, packs it
// into 32-bit words and writes them to IMEM while holding the CPU stalled.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned MAX_WORDS  = 512,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t                  state;
  logic [15:0]             len;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              pk_count;
  logic                    xfer;
  logic                    start_acc;
  logic [15:0]             hdr_len;
  logic                    last_payload;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  // Handshake, start qualification and end-of-payload detection.
  always_comb begin
    xfer         = in_valid && in_ready;
    start_acc    = start && (state == IDLE || state == DONE || state == ERR);
    hdr_len      = {len[15:8], in_data};
    last_payload = (pk_count == 2'(BYTES_PER_WORD - 1)) &&
                   (32'(len) == 32'(word_idx) + 32'd1);
  end

  imem_byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_acc),
    .byte_en    (xfer && (state == DATA)),
    .byte_in    (in_data),
    .count      (pk_count),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  assign mem_addr = 32'({word_idx, 2'b00});

  // Word index: restarts on each accepted start, advances after every write.
  // Start wins over a write pending in the first DONE cycle; that write still
  // goes out with the address shown during the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       word_idx <= '0;
    else if (start_acc) word_idx <= '0;
    else if (mem_we)    word_idx <= word_idx + 1'b1;
  end

  // Load control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      len      <= '0;
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start_acc) begin
            state    <= LEN_HI;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len <= hdr_len;
            if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else if (32'(hdr_len) > MAX_WORDS) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
            if (last_payload) state <= CHK;
`else
            if (last_payload) begin
              state    <= DONE;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule
